// File: rtl/box_motion.sv
// Per-frame box position generator: manual button moves or auto edge bouncing, updated once at vertical blank.
// Optional macro BOX_MOTION_AUTO_EN enables auto/bounce mode; without it the block is manual-only and bounce is 0.
module box_motion #(
    parameter int BOX_X    = 320,
    parameter int BOX_Y    = 240,
    parameter int SIZE     = 32,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int STEP     = 4,
    parameter int SPEED    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] y,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       auto_mode,
    output logic [9:0] box_x,
    output logic [9:0] box_y,
    output logic       frame_tick,
    output logic       bounce
);

    localparam logic signed [10:0] X_MIN  = 11'(SIZE / 2);
    localparam logic signed [10:0] X_MAX  = 11'(H_ACTIVE - 1 - SIZE / 2);
    localparam logic signed [10:0] Y_MIN  = 11'(SIZE / 2);
    localparam logic signed [10:0] Y_MAX  = 11'(V_ACTIVE - 1 - SIZE / 2);
    localparam logic signed [10:0] STEP_S = 11'(STEP);

    logic [4:0] sync_q1;
    logic [4:0] sync_q2;
    logic       blank_d;
    logic       at_blank;
    logic       upd;

    logic up_s, down_s, left_s, right_s;

    logic signed [10:0] pos_x, pos_y;
    logic signed [10:0] man_x, man_y;
    logic signed [10:0] nxt_x, nxt_y;

    function automatic logic signed [10:0] clamp(input logic signed [10:0] v,
                                                 input logic signed [10:0] lo,
                                                 input logic signed [10:0] hi);
        if (v < lo)
            return lo;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

    // Two-flop synchroniser; bit 4 carries auto_mode even when it is not used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= {auto_mode, btn_right, btn_left, btn_down, btn_up};
            sync_q2 <= sync_q1;
        end
    end

    assign up_s    = sync_q2[0];
    assign down_s  = sync_q2[1];
    assign left_s  = sync_q2[2];
    assign right_s = sync_q2[3];

    assign at_blank = (y == 10'(V_ACTIVE));
    assign upd      = at_blank && !blank_d;

    assign pos_x = $signed({1'b0, box_x});
    assign pos_y = $signed({1'b0, box_y});

    always_comb begin
        man_x = pos_x;
        man_y = pos_y;
        if (right_s && !left_s)
            man_x = pos_x + STEP_S;
        else if (left_s && !right_s)
            man_x = pos_x - STEP_S;
        if (down_s && !up_s)
            man_y = pos_y + STEP_S;
        else if (up_s && !down_s)
            man_y = pos_y - STEP_S;
        man_x = clamp(man_x, X_MIN, X_MAX);
        man_y = clamp(man_y, Y_MIN, Y_MAX);
    end

`ifdef BOX_MOTION_AUTO_EN
    localparam logic signed [10:0] SPEED_S = 11'(SPEED);

    logic               auto_s;
    logic               dir_x, dir_y;
    logic               nxt_dir_x, nxt_dir_y;
    logic signed [10:0] aut_x, aut_y;
    logic               flip;

    assign auto_s = sync_q2[4];

    // Overshooting or touching an edge parks the box on it and reverses that axis.
    always_comb begin
        aut_x     = dir_x ? pos_x + SPEED_S : pos_x - SPEED_S;
        aut_y     = dir_y ? pos_y + SPEED_S : pos_y - SPEED_S;
        nxt_dir_x = dir_x;
        nxt_dir_y = dir_y;
        if (aut_x >= X_MAX) begin
            aut_x     = X_MAX;
            nxt_dir_x = 1'b0;
        end else if (aut_x <= X_MIN) begin
            aut_x     = X_MIN;
            nxt_dir_x = 1'b1;
        end
        if (aut_y >= Y_MAX) begin
            aut_y     = Y_MAX;
            nxt_dir_y = 1'b0;
        end else if (aut_y <= Y_MIN) begin
            aut_y     = Y_MIN;
            nxt_dir_y = 1'b1;
        end
        flip  = (nxt_dir_x != dir_x) || (nxt_dir_y != dir_y);
        nxt_x = auto_s ? aut_x : man_x;
        nxt_y = auto_s ? aut_y : man_y;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_x  <= 1'b1;
            dir_y  <= 1'b1;
            bounce <= 1'b0;
        end else if (upd && auto_s) begin
            dir_x  <= nxt_dir_x;
            dir_y  <= nxt_dir_y;
            bounce <= flip;
        end else begin
            bounce <= 1'b0;
        end
    end
`else
    logic unused_auto;

    assign unused_auto = sync_q2[4];
    assign nxt_x       = man_x;
    assign nxt_y       = man_y;
    assign bounce      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_d    <= 1'b0;
            box_x      <= 10'(BOX_X);
            box_y      <= 10'(BOX_Y);
            frame_tick <= 1'b0;
        end else begin
            blank_d    <= at_blank;
            frame_tick <= upd;
            if (upd) begin
                box_x <= nxt_x[9:0];
                box_y <= nxt_y[9:0];
            end
        end
    end

endmodule

// File: tb/tb_box_motion.sv
// Directed self-checking bench for box_motion; auto-mode scenarios follow BOX_MOTION_AUTO_EN.
module tb_box_motion;

    logic       clk;
    logic       rst_n;
    logic [9:0] y;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic       auto_mode;
    logic [9:0] box_x, box_y;
    logic       frame_tick;
    logic       bounce;

    int checks = 0;
    int errors = 0;

    logic [9:0] obs_x, obs_y;
    logic       obs_tick, obs_bounce, obs_tick_after, obs_bounce_after;

    box_motion dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .y          (y),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .auto_mode  (auto_mode),
        .box_x      (box_x),
        .box_y      (box_y),
        .frame_tick (frame_tick),
        .bounce     (bounce)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one short frame and captures outputs on the update cycle and the cycle after.
    task automatic run_frame();
        @(negedge clk) y = 10'd480;
        @(posedge clk);
        #1;
        obs_x      = box_x;
        obs_y      = box_y;
        obs_tick   = frame_tick;
        obs_bounce = bounce;
        @(negedge clk) y = 10'd0;
        @(negedge clk);
        obs_tick_after   = frame_tick;
        obs_bounce_after = bounce;
        @(negedge clk);
    endtask

    task automatic set_buttons(input logic u, input logic d, input logic l, input logic r);
        @(negedge clk);
        btn_up = u; btn_down = d; btn_left = l; btn_right = r;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        int ticks;
        int tick_row;
        rst_n = 1'b0; y = 10'd0; auto_mode = 1'b0;
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
        #12;
        checks++; if (box_x !== 10'd320) begin errors++; $display("[TB] FAIL reset_x got %0d want 320", box_x); end
        checks++; if (box_y !== 10'd240) begin errors++; $display("[TB] FAIL reset_y got %0d want 240", box_y); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("[TB] FAIL reset_tick got %b want 0", frame_tick); end
        checks++; if (bounce !== 1'b0) begin errors++; $display("[TB] FAIL reset_bounce got %b want 0", bounce); end
        @(negedge clk) rst_n = 1'b1;
        ticks = 0; tick_row = -1;
        for (int r = 0; r < 525; r++) begin
            @(negedge clk) y = 10'(r);
            @(posedge clk);
            #1;
            if (frame_tick === 1'b1) begin
                ticks++;
                tick_row = r;
            end
        end
        checks++; if (ticks != 1) begin errors++; $display("[TB] FAIL sweep_tick_count got %0d want 1", ticks); end
        checks++; if (tick_row != 480) begin errors++; $display("[TB] FAIL sweep_tick_row got %0d want 480", tick_row); end
        checks++; if (box_x !== 10'd320 || box_y !== 10'd240) begin
            errors++; $display("[TB] FAIL sweep_pos got %0d,%0d want 320,240", box_x, box_y);
        end
    endtask

    task automatic test_manual_right();
        set_buttons(0, 0, 0, 1);
        for (int i = 1; i <= 3; i++) begin
            run_frame();
            checks++; if (obs_x !== 10'(320 + 4 * i)) begin errors++; $display("[TB] FAIL right_x got %0d want %0d", obs_x, 320 + 4 * i); end
            checks++; if (obs_y !== 10'd240) begin errors++; $display("[TB] FAIL right_y got %0d want 240", obs_y); end
            checks++; if (obs_tick !== 1'b1 || obs_tick_after !== 1'b0) begin
                errors++; $display("[TB] FAIL right_tick got %b%b want 10", obs_tick, obs_tick_after);
            end
        end
    endtask

    task automatic test_both_pressed();
        set_buttons(1, 1, 1, 1);
        run_frame();
        checks++; if (obs_x !== 10'd332 || obs_y !== 10'd240) begin
            errors++; $display("[TB] FAIL both_pressed got %0d,%0d want 332,240", obs_x, obs_y);
        end
    endtask

    task automatic test_clamp();
        int ex;
        int ey;
        set_buttons(0, 0, 1, 0);
        ex = 332;
        for (int i = 0; i < 82; i++) begin
            run_frame();
            ex = (ex - 4 < 16) ? 16 : ex - 4;
            if (obs_x !== 10'(ex)) begin
                checks++; errors++; $display("[TB] FAIL clamp_left_step got %0d want %0d", obs_x, ex);
            end
        end
        checks++; if (obs_x !== 10'd16) begin errors++; $display("[TB] FAIL clamp_left got %0d want 16", obs_x); end
        set_buttons(0, 1, 0, 0);
        ey = 240;
        for (int i = 0; i < 57; i++) begin
            run_frame();
            ey = (ey + 4 > 463) ? 463 : ey + 4;
            if (obs_y !== 10'(ey)) begin
                checks++; errors++; $display("[TB] FAIL clamp_down_step got %0d want %0d", obs_y, ey);
            end
        end
        checks++; if (obs_y !== 10'd463) begin errors++; $display("[TB] FAIL clamp_down got %0d want 463", obs_y); end
        checks++; if (obs_x !== 10'd16) begin errors++; $display("[TB] FAIL clamp_down_x got %0d want 16", obs_x); end
        set_buttons(1, 0, 0, 0);
        run_frame();
        checks++; if (obs_y !== 10'd459) begin errors++; $display("[TB] FAIL up_from_max got %0d want 459", obs_y); end
    endtask

    task automatic test_hold_blank();
        int ticks;
        set_buttons(0, 0, 0, 1);
        ticks = 0;
        @(negedge clk) y = 10'd480;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (frame_tick === 1'b1) ticks++;
        end
        @(negedge clk) y = 10'd0;
        checks++; if (ticks != 1) begin errors++; $display("[TB] FAIL hold_tick_count got %0d want 1", ticks); end
        checks++; if (box_x !== 10'd20) begin errors++; $display("[TB] FAIL hold_x got %0d want 20", box_x); end
    endtask

    task automatic test_mode_toggle();
        set_buttons(0, 0, 0, 0);
        @(negedge clk) y = 10'd100; auto_mode = 1'b1;
        repeat (5) @(negedge clk);
        auto_mode = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (box_x !== 10'd20 || box_y !== 10'd459 || frame_tick !== 1'b0) begin
            errors++; $display("[TB] FAIL toggle_hold got %0d,%0d tick %b want 20,459 tick 0", box_x, box_y, frame_tick);
        end
        @(negedge clk) y = 10'd0;
    endtask

    task automatic test_reset_mid();
        set_buttons(0, 0, 0, 1);
        @(negedge clk) y = 10'd200;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (box_x !== 10'd320 || box_y !== 10'd240 || frame_tick !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_reset got %0d,%0d tick %b want 320,240 tick 0", box_x, box_y, frame_tick);
        end
        @(negedge clk) y = 10'd480;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (frame_tick !== 1'b1 || box_x !== 10'd320) begin
            errors++; $display("[TB] FAIL release_at_blank got tick %b x %0d want tick 1 x 320", frame_tick, box_x);
        end
        @(negedge clk) y = 10'd0;
        set_buttons(0, 0, 0, 0);
    endtask

`ifdef BOX_MOTION_AUTO_EN
    task automatic test_auto_bounce();
        int exp_x [4] = '{622, 623, 621, 619};
        logic exp_b [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        set_buttons(0, 0, 0, 1);
        for (int i = 0; i < 75; i++) run_frame();
        checks++; if (obs_x !== 10'd620) begin errors++; $display("[TB] FAIL auto_setup got %0d want 620", obs_x); end
        set_buttons(0, 0, 0, 0);
        @(negedge clk) y = 10'd100; auto_mode = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (box_x !== 10'd620 || box_y !== 10'd240) begin
            errors++; $display("[TB] FAIL auto_toggle got %0d,%0d want 620,240", box_x, box_y);
        end
        @(negedge clk) y = 10'd0;
        for (int i = 0; i < 4; i++) begin
            run_frame();
            checks++; if (obs_x !== 10'(exp_x[i])) begin errors++; $display("[TB] FAIL auto_x got %0d want %0d", obs_x, exp_x[i]); end
            checks++; if (obs_y !== 10'(242 + 2 * i)) begin errors++; $display("[TB] FAIL auto_y got %0d want %0d", obs_y, 242 + 2 * i); end
            checks++; if (obs_bounce !== exp_b[i] || obs_bounce_after !== 1'b0) begin
                errors++; $display("[TB] FAIL auto_bounce got %b%b want %b0", obs_bounce, obs_bounce_after, exp_b[i]);
            end
        end
    endtask
`else
    task automatic test_auto_ignored();
        int   ex;
        logic any_bounce;
        @(negedge clk) auto_mode = 1'b1;
        set_buttons(0, 0, 0, 1);
        ex = 320;
        any_bounce = 1'b0;
        for (int i = 0; i < 77; i++) begin
            run_frame();
            ex = (ex + 4 > 623) ? 623 : ex + 4;
            if (obs_bounce !== 1'b0 || obs_bounce_after !== 1'b0) any_bounce = 1'b1;
            if (obs_x !== 10'(ex)) begin
                checks++; errors++; $display("[TB] FAIL manual_only_step got %0d want %0d", obs_x, ex);
            end
        end
        checks++; if (obs_x !== 10'd623) begin errors++; $display("[TB] FAIL manual_only_edge got %0d want 623", obs_x); end
        checks++; if (obs_y !== 10'd240) begin errors++; $display("[TB] FAIL manual_only_y got %0d want 240", obs_y); end
        checks++; if (any_bounce !== 1'b0) begin errors++; $display("[TB] FAIL bounce_tied got %b want 0", any_bounce); end
    endtask
`endif

    initial begin
        test_reset();
        test_manual_right();
        test_both_pressed();
        test_clamp();
        test_hold_blank();
        test_mode_toggle();
        test_reset_mid();
`ifdef BOX_MOTION_AUTO_EN
        test_auto_bounce();
`else
        test_auto_ignored();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
